// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a registered one-hot
// grant, rotating priority pointer and a hold-time watchdog.
module rr_arbiter4 #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    win;
  logic          win_found;
  logic          rel;

  // Priority search starting at ptr, wrapping mod 4; first requester wins.
  always_comb begin
    win       = 2'd0;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && req[ptr_q + 2'(k)]) begin
        win       = ptr_q + 2'(k);
        win_found = 1'b1;
      end
    end
  end

  // Holder releases by strobing done or by dropping its own request.
  assign rel = done[gnt_id_q] | ~req[gnt_id_q];

  // Next-state: grant from IDLE, release or watchdog revocation from BUSY.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = BUSY;
          gnt_d       = 4'b0001 << win;
          gnt_id_d    = win;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      BUSY: begin
        if (rel || cnt_q == CNT_LAST) begin
          // Release takes precedence, so timeout only fires without one.
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_id_d    = 2'd0;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
          ptr_d       = gnt_id_q + 2'd1;
          timeout_d   = ~rel;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset overrides any grant in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed stimulus with a grant scoreboard; a negedge monitor
// pops expected grants and checks holder, hold length, gap and timeout.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int hold;
    bit to;
    int gap;   // required idle cycles before this grant; 0 = not checked
  } exp_t;

  exp_t q[$];

  rr_arbiter4 #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int id, input int hold, input bit to, input int gap);
    exp_t e;
    e.id = id; e.hold = hold; e.to = to; e.gap = gap;
    q.push_back(e);
  endtask

  // Monitor: samples on negedge, away from the active edge.
  bit   prev_v   = 1'b0;
  int   hold_cnt = 0;
  int   idle_cnt = 0;
  exp_t cur;
  always @(negedge clk) begin
    chk("valid_vs_gnt", int'(gnt_valid), int'(gnt != 4'b0000));
    if (gnt_valid && !prev_v) begin
      if (q.size() == 0) begin
        chk("unexpected_grant", int'(gnt), 0);
        cur.id = -1; cur.hold = 0; cur.to = 1'b0; cur.gap = 0;
      end else begin
        cur = q.pop_front();
        chk("grant_onehot", int'(gnt), 1 << cur.id);
        chk("grant_id", int'(gnt_id), cur.id);
        if (cur.gap != 0) chk("grant_gap", idle_cnt, cur.gap);
      end
      chk("timeout_idle", int'(timeout), 0);
      hold_cnt = 1;
    end else if (gnt_valid && prev_v) begin
      chk("timeout_busy", int'(timeout), 0);
      hold_cnt++;
    end else if (!gnt_valid && prev_v) begin
      chk("hold_len", hold_cnt, cur.hold);
      chk("timeout_pulse", int'(timeout), int'(cur.to));
      chk("gnt_id_zero", int'(gnt_id), 0);
      idle_cnt = 1;
    end else begin
      chk("timeout_idle", int'(timeout), 0);
      idle_cnt++;
    end
    prev_v = gnt_valid;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_gnt_id"}, int'(gnt_id), 0);
    chk({tag, "_gnt_valid"}, int'(gnt_valid), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    int rot [6] = '{3, 0, 1, 2, 3, 0};
    reset = 1'b1; req = 4'b0000; done = 4'b0000;
    cyc(2);
    chk_zero("reset");

    // Single request, released by done in its 3rd grant cycle; ptr -> 3.
    reset = 1'b0; req = 4'b0100;
    push(2, 3, 1'b0, 0);
    cyc(1);
    cyc(2);
    done = 4'b0100;
    cyc(1);
    done = 4'b0000;

    // Rotation from ptr 3: 3,0,1,2,3,0 with one idle cycle between grants.
    req = 4'b1111;
    foreach (rot[i]) begin
      push(rot[i], 1, 1'b0, 1);
      cyc(1);
      done = 4'b0001 << rot[i];
      cyc(1);
      done = 4'b0000;
    end

    // Priority skip from ptr 1 with req 1001: 3 then 0.
    req = 4'b1001;
    push(3, 2, 1'b0, 1);
    cyc(2);
    done = 4'b1000;
    cyc(1);
    done = 4'b0000;
    push(0, 2, 1'b0, 1);
    cyc(2);
    done = 4'b0001;
    cyc(1);
    done = 4'b0000;
    req = 4'b0000;
    cyc(2);

    // Watchdog: 4-cycle hold then timeout, regrant after one idle cycle,
    // then done in the 4th grant cycle beats the watchdog.
    req = 4'b0010;
    push(1, 4, 1'b1, 0);
    push(1, 4, 1'b0, 1);
    cyc(1);
    cyc(4);
    cyc(1);
    cyc(3);
    done = 4'b0010;
    cyc(1);
    done = 4'b0000;
    req = 4'b0000;
    cyc(2);

    // Stray done during a grant to 0, then reset mid-grant.
    req = 4'b0001;
    push(0, 2, 1'b0, 0);
    cyc(1);
    done = 4'b0110;
    cyc(1);
    done = 4'b0000;
    reset = 1'b1;
    cyc(1);
    chk_zero("midreset");
    reset = 1'b0;
    req = 4'b1111;
    push(0, 1, 1'b0, 1);
    cyc(1);
    done = 4'b0001;
    cyc(1);
    done = 4'b0000;
    req = 4'b0000;
    cyc(3);

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
